// File: rtl/sim_check_pkg.sv
// Shared definitions for the stimulus/check sequencer: FSM encoding and
// sizing helpers used by the sequencer and its comparator.
package sim_check_pkg;

    localparam logic [2:0] ST_IDLE  = 3'd0;
    localparam logic [2:0] ST_LOAD  = 3'd1;
    localparam logic [2:0] ST_GO_HI = 3'd2;
    localparam logic [2:0] ST_GO_LO = 3'd3;
    localparam logic [2:0] ST_CHECK = 3'd4;
    localparam logic [2:0] ST_DONE  = 3'd5;

    typedef enum logic [2:0] {
        S_IDLE  = ST_IDLE,
        S_LOAD  = ST_LOAD,
        S_GO_HI = ST_GO_HI,
        S_GO_LO = ST_GO_LO,
        S_CHECK = ST_CHECK,
        S_DONE  = ST_DONE
    } state_t;

    // Bits needed to hold a population count of n flags.
    function automatic int popcnt_w(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/sim_check_cmp.sv
// Per-channel tolerance comparator: flags a channel when |v_out - expt| > tol.
module sim_check_cmp
    import sim_check_pkg::*;
#(
    parameter int N_CH  = 2,
    parameter int WIDTH = 18
) (
    input  logic [N_CH*WIDTH-1:0] v_out,
    input  logic [N_CH*WIDTH-1:0] expt,
    input  logic [WIDTH-1:0]      tol,
    output logic [N_CH-1:0]       fail
);

    genvar gi;
    generate
        for (gi = 0; gi < N_CH; gi++) begin : g_ch
            logic signed [WIDTH:0] diff;
            logic        [WIDTH:0] mag;

            // One extra bit keeps the difference exact across the full signed range.
            assign diff = $signed({v_out[gi*WIDTH+WIDTH-1], v_out[gi*WIDTH +: WIDTH]})
                        - $signed({expt[gi*WIDTH+WIDTH-1], expt[gi*WIDTH +: WIDTH]});
            assign mag  = diff[WIDTH] ? $unsigned(-diff) : $unsigned(diff);
            assign fail[gi] = (mag > {1'b0, tol});
        end
    endgenerate

endmodule

// File: rtl/sim_check_seq.sv
// Step sequencer: loads stimulus, strobes go_out, waits to settle, then
// compares the DUT response against the expectation with a tolerance.
module sim_check_seq
    import sim_check_pkg::*;
#(
    parameter int N_CH      = 2,
    parameter int WIDTH     = 18,
    parameter int HI_CYCLES = 4,
    parameter int LO_CYCLES = 4,
    parameter int N_STEPS   = 25,
    parameter int ERR_W     = 16
) (
    input  logic                          emu_clk,
    input  logic                          emu_rst_n,
    input  logic                          start,
    input  logic                          step_valid,
    output logic                          step_ready,
    input  logic [N_CH*WIDTH-1:0]         step_stim,
    input  logic [N_CH*WIDTH-1:0]         step_expt,
    input  logic [WIDTH-1:0]              tol,
    output logic [N_CH*WIDTH-1:0]         v_in,
    input  logic [N_CH*WIDTH-1:0]         v_out,
    output logic                          go_out,
    output logic                          busy,
    output logic                          done,
    output logic [N_CH-1:0]               ch_fail,
    output logic [ERR_W-1:0]              err_cnt,
    output logic [$clog2(N_STEPS+1)-1:0]  step_idx
);

    localparam int SW      = $clog2(N_STEPS + 1);
    localparam int PW      = popcnt_w(N_CH);
    localparam int SUMW    = ((ERR_W > PW) ? ERR_W : PW) + 1;
    localparam int CNT_MAX = (HI_CYCLES > LO_CYCLES) ? HI_CYCLES : LO_CYCLES;
    localparam int CW      = $clog2(CNT_MAX + 1);

    state_t                 state_reg;
    logic [CW-1:0]          cnt_reg;
    logic [N_CH*WIDTH-1:0]  v_in_reg;
    logic [N_CH*WIDTH-1:0]  expt_reg;
    logic                   go_reg;
    logic [N_CH-1:0]        ch_fail_reg;
    logic [ERR_W-1:0]       err_reg;
    logic [SW-1:0]          step_reg;

    logic [N_CH-1:0]        fail_vec;
    logic [PW-1:0]          fail_pop;
    logic [SUMW-1:0]        err_sum;
    logic [ERR_W-1:0]       err_next;
    logic [SW-1:0]          step_next;

    sim_check_cmp #(
        .N_CH  (N_CH),
        .WIDTH (WIDTH)
    ) u_cmp (
        .v_out (v_out),
        .expt  (expt_reg),
        .tol   (tol),
        .fail  (fail_vec)
    );

    always_comb begin
        fail_pop = '0;
        for (int i = 0; i < N_CH; i++) begin
            fail_pop = fail_pop + PW'(fail_vec[i]);
        end
    end

    // Saturating accumulate of failed channel checks.
    assign err_sum   = SUMW'(err_reg) + SUMW'(fail_pop);
    assign err_next  = (err_sum > SUMW'({ERR_W{1'b1}})) ? {ERR_W{1'b1}} : err_sum[ERR_W-1:0];
    assign step_next = step_reg + SW'(1);

    always_ff @(posedge emu_clk) begin
        if (!emu_rst_n) begin
            state_reg   <= S_IDLE;
            cnt_reg     <= '0;
            v_in_reg    <= '0;
            expt_reg    <= '0;
            go_reg      <= 1'b0;
            ch_fail_reg <= '0;
            err_reg     <= '0;
            step_reg    <= '0;
        end else begin
            case (state_reg)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        ch_fail_reg <= '0;
                        err_reg     <= '0;
                        step_reg    <= '0;
                        state_reg   <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    if (step_valid) begin
                        v_in_reg  <= step_stim;
                        expt_reg  <= step_expt;
                        cnt_reg   <= CW'(HI_CYCLES - 1);
                        go_reg    <= 1'b1;
                        state_reg <= S_GO_HI;
                    end
                end
                S_GO_HI: begin
                    // The same counter is reloaded here to time the settle phase.
                    if (cnt_reg == '0) begin
                        go_reg    <= 1'b0;
                        cnt_reg   <= CW'(LO_CYCLES - 1);
                        state_reg <= S_GO_LO;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                S_GO_LO: begin
                    if (cnt_reg == '0) begin
                        state_reg <= S_CHECK;
                    end else begin
                        cnt_reg <= cnt_reg - CW'(1);
                    end
                end
                S_CHECK: begin
                    ch_fail_reg <= ch_fail_reg | fail_vec;
                    err_reg     <= err_next;
                    step_reg    <= step_next;
                    state_reg   <= (step_next < SW'(N_STEPS)) ? S_LOAD : S_DONE;
                end
                default: begin
                    go_reg    <= 1'b0;
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    assign step_ready = (state_reg == S_LOAD);
    assign busy       = (state_reg != S_IDLE) && (state_reg != S_DONE);
    assign done       = (state_reg == S_DONE);
    assign v_in       = v_in_reg;
    assign go_out     = go_reg;
    assign ch_fail    = ch_fail_reg;
    assign err_cnt    = err_reg;
    assign step_idx   = step_reg;

endmodule
